// File: rtl/twos_frame_accumulator_pkg.sv
// Shared types and width helpers for the frame accumulator block.
// Provides the two-state FSM encoding and a constant ceil(log2) function.
package twos_frame_accumulator_pkg;

  localparam int DATA_W = 9;

  typedef enum logic {
    ACC = 1'b0,
    OUT = 1'b1
  } state_t;

  // Returns ceil(log2(value)); clog2(1) = 0. Usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/twos_frame_accumulator_frame_minmax.sv
// Registered signed min/max tracker: load seeds both extremes with the first
// sample, update widens them, clear returns both to zero.
module frame_minmax
  import twos_frame_accumulator_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_update,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_min,
  output logic [DATA_W-1:0] o_max
);

  logic signed [DATA_W-1:0] r_min;
  logic signed [DATA_W-1:0] r_max;
  logic signed [DATA_W-1:0] w_data;

  assign w_data = $signed(i_data);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_min <= '0;
      r_max <= '0;
    end else if (i_load) begin
      r_min <= w_data;
      r_max <= w_data;
    end else if (i_update) begin
      if (w_data < r_min) r_min <= w_data;
      if (w_data > r_max) r_max <= w_data;
    end
  end

  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/twos_frame_accumulator.sv
// Collects signed 9-bit samples into frames of up to FRAME_LEN and presents
// sum/count/min/max through a valid/ready result port; io_flush closes early.
module twos_frame_accumulator
  import twos_frame_accumulator_pkg::*;
#(
  parameter  int FRAME_LEN = 8,
  localparam int CNT_W     = clog2(FRAME_LEN + 1),
  localparam int SUM_W     = 9 + clog2(FRAME_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_data,
  input  logic              io_flush,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic [SUM_W-1:0]  io_out_sum,
  output logic [CNT_W-1:0]  io_out_count,
  output logic [DATA_W-1:0] io_out_min,
  output logic [DATA_W-1:0] io_out_max
);

  state_t              r_state;
  state_t              w_state_next;
  logic [SUM_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_count;

  logic                w_in_acc;
  logic                w_accept;
  logic                w_close;
  logic                w_release;
  logic [SUM_W-1:0]    w_sample_ext;
  logic [CNT_W-1:0]    w_count_inc;
  logic [DATA_W-1:0]   w_min;
  logic [DATA_W-1:0]   w_max;

  assign w_in_acc     = (r_state == ACC);
  assign w_accept     = io_in_valid && w_in_acc;
  assign w_sample_ext = {{(SUM_W - DATA_W){io_in_data[DATA_W-1]}}, io_in_data};
  assign w_count_inc  = r_count + CNT_W'(1);

  // A flush closes the frame only if it holds a sample, counting one accepted
  // in the same cycle.
  assign w_close   = w_in_acc &&
                     ((w_accept && (w_count_inc == CNT_W'(FRAME_LEN))) ||
                      (io_flush && ((r_count != '0) || w_accept)));
  assign w_release = (r_state == OUT) && io_out_ready;

  always_ff @(posedge clock) begin
    if (!reset) r_state <= ACC;
    else        r_state <= w_state_next;
  end

  // NOTE: default assignment first so no path leaves w_state_next unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ACC:     if (w_close)      w_state_next = OUT;
      OUT:     if (io_out_ready) w_state_next = ACC;
      default:                   w_state_next = ACC;
    endcase
  end

  // The accumulators themselves hold the result in OUT: nothing is accepted
  // there, so they stay frozen until the result is taken.
  always_ff @(posedge clock) begin
    if (!reset || w_release) begin
      r_sum   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_sum   <= r_sum + w_sample_ext;
      r_count <= w_count_inc;
    end
  end

  frame_minmax u_minmax (
    .clock    (clock),
    .reset    (reset),
    .i_load   (w_accept && (r_count == '0)),
    .i_update (w_accept && (r_count != '0)),
    .i_clear  (w_release),
    .i_data   (io_in_data),
    .o_min    (w_min),
    .o_max    (w_max)
  );

  always_comb begin
    io_in_ready  = w_in_acc;
    io_out_valid = !w_in_acc;
    io_out_sum   = '0;
    io_out_count = '0;
    io_out_min   = '0;
    io_out_max   = '0;
    if (r_state == OUT) begin
      io_out_sum   = r_sum;
      io_out_count = r_count;
      io_out_min   = w_min;
      io_out_max   = w_max;
    end
  end

endmodule

// File: tb/tb_twos_frame_accumulator.sv
// Bench for twos_frame_accumulator: a queue-based frame model checked against
// the DUT every cycle, directed scenarios with literal results, then random traffic.
module tb_twos_frame_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;
  localparam int SUM_W     = 12;

  typedef struct {
    int sum;
    int cnt;
    int mn;
    int mx;
  } res_t;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [8:0]       io_in_data;
  logic             io_flush;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [SUM_W-1:0] io_out_sum;
  logic [CNT_W-1:0] io_out_count;
  logic [8:0]       io_out_min;
  logic [8:0]       io_out_max;

  int n_cmp = 0;
  int n_bad = 0;

  twos_frame_accumulator #(.FRAME_LEN(FRAME_LEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_data   (io_in_data),
    .io_flush     (io_flush),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_sum   (io_out_sum),
    .io_out_count (io_out_count),
    .io_out_min   (io_out_min),
    .io_out_max   (io_out_max)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input integer act, input integer exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the open frame is a queue of samples; the result is
  // computed from the whole queue when the frame closes.
  bit   m_known = 1'b0;
  bit   m_out   = 1'b0;
  int   m_frame[$];
  res_t m_res;
  res_t res_q[$];

  always @(posedge clock) begin
    if (!reset) begin
      m_known = 1'b1;
      m_out   = 1'b0;
      m_frame.delete();
    end else if (m_known) begin
      if (!m_out) begin
        if (io_in_valid) m_frame.push_back(int'($signed(io_in_data)));
        if ((io_in_valid && m_frame.size() == FRAME_LEN) ||
            (io_flush && m_frame.size() > 0)) begin
          m_res.sum = 0;
          m_res.cnt = m_frame.size();
          m_res.mn  = m_frame[0];
          m_res.mx  = m_frame[0];
          foreach (m_frame[i]) begin
            m_res.sum += m_frame[i];
            if (m_frame[i] < m_res.mn) m_res.mn = m_frame[i];
            if (m_frame[i] > m_res.mx) m_res.mx = m_frame[i];
          end
          m_out = 1'b1;
        end
      end else if (io_out_ready) begin
        res_q.push_back(m_res);
        m_out = 1'b0;
        m_frame.delete();
      end
    end
  end

  always @(negedge clock) begin
    if (m_known) begin
      check("in_ready",  integer'(io_in_ready),  integer'(!m_out));
      check("out_valid", integer'(io_out_valid), integer'(m_out));
      check("out_sum",   integer'($signed(io_out_sum)), m_out ? m_res.sum : 0);
      check("out_count", integer'(io_out_count),        m_out ? m_res.cnt : 0);
      check("out_min",   integer'($signed(io_out_min)), m_out ? m_res.mn  : 0);
      check("out_max",   integer'($signed(io_out_max)), m_out ? m_res.mx  : 0);
    end
  end

  task automatic drive(input bit v, input logic [8:0] d, input bit f);
    io_in_valid = v;
    io_in_data  = d;
    io_flush    = f;
    @(negedge clock);
  endtask

  task automatic check_out(input string name, input int s, input int c,
                           input int mn, input int mx);
    check({name, " valid"}, integer'(io_out_valid), 1);
    check({name, " sum"},   integer'($signed(io_out_sum)), s);
    check({name, " count"}, integer'(io_out_count), c);
    check({name, " min"},   integer'($signed(io_out_min)), mn);
    check({name, " max"},   integer'($signed(io_out_max)), mx);
  endtask

  task automatic expect_result(input string name, input int n_before, input int s,
                               input int c, input int mn, input int mx);
    res_t r;
    check({name, " results"}, res_q.size(), n_before + 1);
    if (res_q.size() > 0) begin
      r = res_q[$];
      check({name, " model sum"},   r.sum, s);
      check({name, " model count"}, r.cnt, c);
      check({name, " model min"},   r.mn,  mn);
      check({name, " model max"},   r.mx,  mx);
    end
  endtask

  initial begin
    int n;
    reset        = 1'b0;
    io_in_valid  = 1'b0;
    io_in_data   = '0;
    io_flush     = 1'b0;
    io_out_ready = 1'b1;
    repeat (2) @(negedge clock);
    check("rst in_ready",  integer'(io_in_ready),  1);
    check("rst out_valid", integer'(io_out_valid), 0);
    check("rst sum",       integer'(io_out_sum),   0);
    check("rst count",     integer'(io_out_count), 0);
    reset = 1'b1;

    // 1..8 with downstream always ready
    n = res_q.size();
    for (int i = 1; i <= 8; i++) drive(1'b1, 9'(i), 1'b0);
    check_out("seq", 36, 8, 1, 8);
    drive(1'b0, '0, 1'b0);
    check("seq ready back", integer'(io_in_ready), 1);
    expect_result("seq", n, 36, 8, 1, 8);

    // most negative samples
    n = res_q.size();
    for (int i = 0; i < 8; i++) drive(1'b1, 9'h100, 1'b0);
    check_out("neg", -2048, 8, -256, -256);
    check("neg raw sum", integer'(io_out_sum), 12'h800);
    drive(1'b0, '0, 1'b0);
    expect_result("neg", n, -2048, 8, -256, -256);

    // early flush, then flush of an empty frame
    n = res_q.size();
    drive(1'b1, 9'd5, 1'b0);
    drive(1'b1, 9'h1FD, 1'b0);
    drive(1'b1, 9'd7, 1'b0);
    drive(1'b0, '0, 1'b1);
    check_out("flush", 9, 3, -3, 7);
    drive(1'b0, '0, 1'b0);
    expect_result("flush", n, 9, 3, -3, 7);
    n = res_q.size();
    repeat (3) drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);
    check("empty flush valid", integer'(io_out_valid), 0);
    check("empty flush results", res_q.size(), n);

    // back-pressure: result held, samples refused
    n = res_q.size();
    io_out_ready = 1'b0;
    for (int i = 0; i < 8; i++) drive(1'b1, 9'd3, 1'b0);
    check_out("stall", 24, 8, 3, 3);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 9'h0AA, 1'b0);
      check_out("stall hold", 24, 8, 3, 3);
      check("stall in_ready", integer'(io_in_ready), 0);
    end
    io_out_ready = 1'b1;
    drive(1'b0, '0, 1'b0);
    expect_result("stall", n, 24, 8, 3, 3);
    n = res_q.size();
    drive(1'b1, 9'd4, 1'b0);
    drive(1'b0, '0, 1'b1);
    check_out("after stall", 4, 1, 4, 4);
    drive(1'b0, '0, 1'b0);
    expect_result("after stall", n, 4, 1, 4, 4);

    // reset mid-frame discards the partial frame
    for (int i = 0; i < 4; i++) drive(1'b1, 9'd1, 1'b0);
    reset = 1'b0;
    drive(1'b0, '0, 1'b0);
    reset = 1'b1;
    check("mid rst in_ready", integer'(io_in_ready), 1);
    n = res_q.size();
    for (int i = 0; i < 8; i++) drive(1'b1, 9'd2, 1'b0);
    check_out("post rst", 16, 8, 2, 2);
    drive(1'b0, '0, 1'b0);
    expect_result("post rst", n, 16, 8, 2, 2);

    // flush coinciding with the third accept
    n = res_q.size();
    drive(1'b1, 9'd10, 1'b0);
    drive(1'b1, 9'd10, 1'b0);
    drive(1'b1, 9'd10, 1'b1);
    check_out("same flush", 30, 3, 10, 10);
    drive(1'b0, '0, 1'b0);
    expect_result("same flush", n, 30, 3, 10, 10);

    // random traffic, checked every cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 399) != 0);
      io_out_ready = ($urandom_range(0, 2) != 0);
      drive($urandom_range(0, 3) != 0, 9'($urandom), $urandom_range(0, 11) == 0);
    end
    reset        = 1'b1;
    io_out_ready = 1'b1;
    repeat (3) drive(1'b0, '0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twos_frame_accumulator.md
TWOS_FRAME_ACCUMULATOR -- requirements
Module: twos_frame_accumulator

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8, meaning samples per frame (legal range 2..256).
REQ-002 SHALL have derived constant CNT_W = clog2(FRAME_LEN+1), meaning count width, and SUM_W = 9 + clog2(FRAME_LEN), meaning sum width (12 at default).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset; state clears on a rising clock edge while reset=0.
REQ-005 SHALL have port io_in_valid  input  1  upstream sample valid.
REQ-006 SHALL have port io_in_ready  output  1  block accepts a sample.
REQ-007 SHALL have port io_in_data  input  9  two's-complement sample, range -256..+255, from the sign/magnitude converter stage.
REQ-008 SHALL have port io_flush  input  1  close the current frame early.
REQ-009 SHALL have port io_out_valid  output  1  frame result valid.
REQ-010 SHALL have port io_out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port io_out_sum  output  SUM_W  signed sum of the frame.
REQ-012 SHALL have port io_out_count  output  CNT_W  number of samples in the frame.
REQ-013 SHALL have port io_out_min  output  9  signed minimum sample of the frame.
REQ-014 SHALL have port io_out_max  output  9  signed maximum sample of the frame.

Function
REQ-015 SHALL implement two states: ACC (collecting samples) and OUT (holding a result).
REQ-016 SHALL drive io_in_ready=1 in ACC and 0 in OUT; there is no bypass.
REQ-017 SHALL accept a sample only on io_in_valid & io_in_ready; on accept it sign-extends the sample to SUM_W, adds it to the sum, increments count, and updates min/max with signed compares.
REQ-018 SHALL load min=max=sample on the first accepted sample of a frame.
REQ-019 SHALL close a frame on the accept that makes count reach FRAME_LEN, or on io_flush=1 in ACC with count>0 (after a same-cycle accept, if any); on close it registers the result and moves to OUT.
REQ-020 SHALL ignore io_flush when in ACC with count=0 and no same-cycle accept, and SHALL ignore io_flush while in OUT.
REQ-021 SHALL assert io_out_valid exactly in OUT, starting in the cycle after the closing accept or flush (latency 1).
REQ-022 SHALL hold io_out_sum, io_out_count, io_out_min and io_out_max stable while io_out_valid=1 and io_out_ready=0.
REQ-023 SHALL, on io_out_valid & io_out_ready, clear sum, count, min and max and return to ACC; io_in_ready goes to 1 in the next cycle.
REQ-024 SHALL never overflow the sum, because SUM_W covers FRAME_LEN x (-256); no saturation logic is required.
REQ-025 SHALL drive io_out_min, io_out_max, io_out_sum and io_out_count as 0 while not in OUT.

Reset
REQ-026 SHALL, while reset=0 at a clock edge, enter ACC with sum=0, count=0, min=max=0, io_out_valid=0 and io_in_ready=1.
REQ-027 SHALL discard any partial frame or pending result when reset asserts mid-operation; no result is emitted for it.

Structure
REQ-028 SHALL place the state encoding (ACC, OUT) and the width helper clog2 in the shared package for the combinational-chapter projects.
REQ-029 SHALL use one sub-module, frame_minmax, a registered signed min/max tracker with load, update and clear inputs; all other logic is inline.

Verification
REQ-030 SHALL cover: 8 samples 1..8, io_out_ready=1 -> sum=36, count=8, min=1, max=8, valid one cycle after the 8th accept.
REQ-031 SHALL cover: 8 samples of -256 (0x100) -> sum=12'h800 (-2048), min=max=-256.
REQ-032 SHALL cover: samples 5, -3, 7 then io_flush -> sum=9, count=3, min=-3, max=7; a flush with count=0 -> no output.
REQ-033 SHALL cover: io_out_ready held 0 for 5 cycles -> outputs stable, io_in_ready=0, no sample lost or accepted.
REQ-034 SHALL cover: reset=0 after 4 samples, then 8 samples of value 2 -> single result sum=16, count=8.
REQ-035 SHALL cover: io_flush in the same cycle as the 3rd accept of value 10 (samples 10,10,10) -> count=3, sum=30.
